cube_frame_scheduler: RTL

//  Sequences full-screen refreshes of the cube-state pixel renderer. Scans (x,y) over the panel raster and

---
 rtl/cube_frame_scheduler.sv | 93 +++++++++
 1 files changed

// File: rtl/cube_frame_scheduler.sv
// Full-screen refresh sequencer: scans the panel raster, streams renderer pixels over valid/ready,
// and freezes a cube-state snapshot per frame so mid-frame updates never tear the image.
module cube_frame_scheduler #(
    parameter int unsigned H_RES = 320,
    parameter int unsigned V_RES = 240
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [143:0] state_in,
    input  logic         state_valid,
    input  logic         refresh_req,
    output logic [8:0]   x,
    output logic [7:0]   y,
    output logic [143:0] snap_state,
    input  logic [15:0]  pixel_in,
    output logic [15:0]  px_data,
    output logic         px_valid,
    input  logic         px_ready,
    output logic         frame_start,
    output logic         busy,
    output logic         frame_done
);
    typedef enum logic [1:0] {IDLE, LATCH, STREAM, DONE} state_t;

    state_t       state;
    state_t       state_next;
    logic [143:0] pending;
    logic         dirty;
    logic         req_flag;
    logic         beat;
    logic         last_col;
    logic         last_row;

    assign last_col    = (x == 9'(H_RES - 1));
    assign last_row    = (y == 8'(V_RES - 1));
    assign beat        = (state == STREAM) && px_ready;

    assign px_data     = pixel_in;
    assign px_valid    = (state == STREAM);
    assign frame_start = (state == STREAM) && (x == '0) && (y == '0);
    assign busy        = (state != IDLE);
    assign frame_done  = (state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (refresh_req || dirty || req_flag) state_next = LATCH;
            LATCH:   state_next = STREAM;
            STREAM:  if (beat && last_col && last_row) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending    <= '0;
            dirty      <= 1'b0;
            req_flag   <= 1'b0;
            snap_state <= '0;
            x          <= '0;
            y          <= '0;
        end else begin
            if (state == LATCH) begin
                snap_state <= pending;
                x          <= '0;
                y          <= '0;
                dirty      <= 1'b0;
                req_flag   <= 1'b0;
            end
            // Later assignments win: a strobe in the LATCH cycle keeps dirty/req_flag set.
            if (state_valid) begin
                pending <= state_in;
                dirty   <= 1'b1;
            end
            if (refresh_req && state != IDLE) req_flag <= 1'b1;

            if (beat && !(last_col && last_row)) begin
                if (last_col) begin
                    x <= '0;
                    y <= y + 8'd1;
                end else begin
                    x <= x + 9'd1;
                end
            end
        end
    end
endmodule
